// File: rtl/pio_in_pkg.sv
// Shared definitions for the parallel input port: register addresses and the bus data width.
package pio_in_pkg;

  localparam int PIO_IN_BUS_W = 32;

  localparam logic [1:0] PIO_IN_ADDR_LVL  = 2'd0;
  localparam logic [1:0] PIO_IN_ADDR_FLAG = 2'd1;
  localparam logic [1:0] PIO_IN_ADDR_MASK = 2'd2;

endpackage

// File: rtl/pio_in_debounce.sv
// Single-bit input conditioner: 2-FF synchronizer, tick-paced sample history, and the
// accepted debounced level.
import pio_in_pkg::*;

module pio_in_debounce #(
  parameter int DB_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sw,
  output logic lvl
);

  logic                sync_p0;
  logic                sync_p1;
  logic [DB_DEPTH-2:0] hist_p2;
  logic [DB_DEPTH-1:0] samp_nxt;

  // The newest synchronized value plus the DB_DEPTH-1 older samples form the full window.
  assign samp_nxt = {hist_p2, sync_p1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      hist_p2 <= '0;
      lvl     <= 1'b0;
    end else begin
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
      // Sample boundary: shift on tick, accept a new level only on a unanimous window
      if (tick) begin
        hist_p2 <= samp_nxt[DB_DEPTH-2:0];
        if (&samp_nxt) begin
          lvl <= 1'b1;
        end else if (~|samp_nxt) begin
          lvl <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/pio_in.sv
// Parallel input port: debounced switch levels and sticky rising-edge flags on the EN/PData bus.
// Build option PIO_IN_IRQ_EN adds a mask register at addr 2 and drives irq = |(flag & mask).
import pio_in_pkg::*;

module pio_in #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 50000,
  parameter int DB_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    EN,
  input  logic                    WE,
  input  logic [1:0]              addr,
  input  logic [PIO_IN_BUS_W-1:0] PData_in,
  output logic [PIO_IN_BUS_W-1:0] PData_out,
  input  logic [WIDTH-1:0]        SW_in,
  output logic                    irq
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0]        tick_cnt;
  logic                    tick;
  logic [WIDTH-1:0]        lvl;
  logic [WIDTH-1:0]        lvl_d;
  logic [WIDTH-1:0]        rise;
  logic [WIDTH-1:0]        flag;
  logic [WIDTH-1:0]        flag_clr;
  logic [WIDTH-1:0]        mask;
  logic                    rd;
  logic                    wr;
  logic [PIO_IN_BUS_W-1:0] rd_data;
  logic                    unused_wdata;

  assign rd   = EN & ~WE;
  assign wr   = EN & WE;
  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));
  // Data bits above WIDTH (and all of them without the mask option) are never stored.
  assign unused_wdata = ^PData_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    pio_in_debounce #(.DB_DEPTH(DB_DEPTH)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .sw    (SW_in[i]),
      .lvl   (lvl[i])
    );
  end

  assign rise = lvl & ~lvl_d;
  // Only bits the CPU actually saw as 1 are cleared, so an edge landing on the read survives.
  assign flag_clr = (rd && addr == PIO_IN_ADDR_FLAG) ? flag : '0;

`ifdef PIO_IN_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
    end else if (wr && addr == PIO_IN_ADDR_MASK) begin
      mask <= PData_in[WIDTH-1:0];
    end
  end

  assign irq = |(flag & mask);
`else
  assign mask = '0;
  assign irq  = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (addr)
      PIO_IN_ADDR_LVL:  rd_data[WIDTH-1:0] = lvl;
      PIO_IN_ADDR_FLAG: rd_data[WIDTH-1:0] = flag;
      PIO_IN_ADDR_MASK: rd_data[WIDTH-1:0] = mask;
      default:          rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_d     <= '0;
      flag      <= '0;
      PData_out <= '0;
    end else begin
      lvl_d <= lvl;
      flag  <= (flag & ~flag_clr) | rise;
      if (rd) begin
        PData_out <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_pio_in.sv
// Self-checking bench for pio_in with TICK_DIV=4, DB_DEPTH=3; covers both PIO_IN_IRQ_EN builds.
import pio_in_pkg::*;

module tb_pio_in;

  localparam int WIDTH    = 8;
  localparam int TICK_DIV = 4;
  localparam int DB_DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EN;
  logic        WE;
  logic [1:0]  addr;
  logic [31:0] PData_in;
  logic [31:0] PData_out;
  logic [7:0]  SW_in;
  logic        irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic [7:0]  sw;
    int          wait_cyc;
    logic [1:0]  a;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  pio_in #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .DB_DEPTH(DB_DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .EN        (EN),
    .WE        (WE),
    .addr      (addr),
    .PData_in  (PData_in),
    .PData_out (PData_out),
    .SW_in     (SW_in),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [1:0] a, input logic [31:0] e, input string nm);
    @(negedge clk);
    EN = 1'b1; WE = 1'b0; addr = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    EN = 1'b0;
    check(name_q.pop_front(), PData_out, exp_q.pop_front());
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    EN = 1'b1; WE = 1'b1; addr = a; PData_in = d;
    @(posedge clk);
    #1;
    EN = 1'b0; WE = 1'b0;
  endtask

  task automatic do_reset(input logic [7:0] sw);
    @(negedge clk);
    rst_n = 1'b0; SW_in = sw; EN = 1'b0; WE = 1'b0;
    #2;
    check("rst_pdata", PData_out, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int hits;
    int others;
    int irq_hi;
    logic done;

    rst_n = 1'b0; EN = 1'b0; WE = 1'b0; addr = 2'd0; PData_in = '0; SW_in = '0;

    vecs[0] = '{8'h00, 20, PIO_IN_ADDR_LVL,  32'h00};
    vecs[1] = '{8'h00,  0, PIO_IN_ADDR_FLAG, 32'h00};
    vecs[2] = '{8'h05, 20, PIO_IN_ADDR_LVL,  32'h05};
    vecs[3] = '{8'h05,  0, PIO_IN_ADDR_FLAG, 32'h05};
    vecs[4] = '{8'h05,  0, PIO_IN_ADDR_FLAG, 32'h00};
    vecs[5] = '{8'h05,  0, 2'd3,             32'h00};
    vecs[6] = '{8'hA5, 20, PIO_IN_ADDR_FLAG, 32'hA0};
    vecs[7] = '{8'hA5,  0, PIO_IN_ADDR_LVL,  32'hA5};
    vecs[8] = '{8'h05, 20, PIO_IN_ADDR_FLAG, 32'h00};

    // Switches held high through reset give one edge per bit after release
    do_reset(8'hFF);
    idle(18);
    do_read(PIO_IN_ADDR_LVL,  32'hFF, "rst_lvl");
    do_read(PIO_IN_ADDR_FLAG, 32'hFF, "rst_flag");
    do_read(PIO_IN_ADDR_FLAG, 32'h00, "rst_flag_clr");

    // Bounce on bit 0 with a 5-cycle half period never settles
    do_reset(8'h00);
    for (int s = 0; s < 8; s++) begin
      SW_in[0] = ~SW_in[0];
      do_read(PIO_IN_ADDR_LVL, 32'h0, "bounce_lvl");
      idle(4);
    end
    SW_in[0] = 1'b1;
    idle(20);
    do_read(PIO_IN_ADDR_LVL,  32'h1, "bounce_settle");
    do_read(PIO_IN_ADDR_FLAG, 32'h1, "bounce_flag");
    do_read(PIO_IN_ADDR_FLAG, 32'h0, "bounce_flag_clr");

    for (int i = 0; i < 9; i++) begin
      SW_in = vecs[i].sw;
      idle(vecs[i].wait_cyc);
      do_read(vecs[i].a, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Writes and idle cycles keep the last read data
    do_read(PIO_IN_ADDR_LVL, 32'h05, "lvl_05");
    do_write(PIO_IN_ADDR_LVL, 32'hFFFF_FFFF);
    check("we_hold", PData_out, 32'h05);
    idle(1);
    check("idle_hold", PData_out, 32'h05);

    // Back-to-back flag reads while bit 3 rises: the read coinciding with the set omits it
    @(negedge clk);
    EN = 1'b1; WE = 1'b0; addr = PIO_IN_ADDR_FLAG; SW_in = 8'h0D;
    hits = 0; others = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk);
      #1;
      if (PData_out == 32'h8) begin
        hits++;
        done = 1'b1;
      end else if (PData_out != 32'h0) begin
        others++;
      end
    end
    EN = 1'b0;
    check("simul_hit", hits, 32'd1);
    check("simul_other", others, 32'd0);
    do_read(PIO_IN_ADDR_FLAG, 32'h0, "simul_after");

`ifdef PIO_IN_IRQ_EN
    SW_in = 8'h09;
    idle(20);
    do_read(PIO_IN_ADDR_FLAG, 32'h0, "irq_pre_flag");
    do_write(PIO_IN_ADDR_MASK, 32'h02);
    do_read(PIO_IN_ADDR_MASK, 32'h02, "mask_rd");
    check("irq_idle", {31'b0, irq}, 32'h0);
    SW_in = 8'h0B;
    for (int c = 0; c < 30; c++) begin
      if (irq) break;
      @(posedge clk);
      #1;
    end
    check("irq_rise", {31'b0, irq}, 32'h1);
    do_read(PIO_IN_ADDR_FLAG, 32'h02, "irq_flag");
    check("irq_drop", {31'b0, irq}, 32'h0);
    SW_in = 8'h0F;
    idle(20);
    check("irq_masked", {31'b0, irq}, 32'h0);
    do_read(PIO_IN_ADDR_FLAG, 32'h04, "irq_masked_flag");
`else
    do_write(PIO_IN_ADDR_MASK, 32'hFF);
    do_read(PIO_IN_ADDR_MASK, 32'h0, "mask_off_rd");
    SW_in = 8'h0B;
    irq_hi = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (irq !== 1'b0) irq_hi++;
    end
    check("irq_off", irq_hi, 32'd0);
    do_read(PIO_IN_ADDR_FLAG, 32'h02, "off_flag");
    do_read(2'd3, 32'h0, "addr3_rd");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
